// File: rtl/ibuf_bitserial_if.sv
// Vector-in / bit-plane-slice-out handshake bundle for ibuf_bitserial.
//   i_valid/o_ready/i_data      : upstream vector handshake (element 0 newest)
//   o_valid/i_ready/o_slice     : downstream slice handshake to the crossbar
//   o_slice_idx/o_last/o_done   : slice weight index, last-slice flag, done pulse
interface ibuf_bitserial_if #(
    parameter int unsigned datatype_size  = 8,
    parameter int unsigned fifo_length    = 5,
    parameter int unsigned bits_per_cycle = 1
);
    localparam int unsigned num_slices = datatype_size / bits_per_cycle;
    localparam int unsigned idx_w      = (num_slices > 1) ? $clog2(num_slices) : 1;

    logic                      i_valid;
    logic                      o_ready;
    logic [datatype_size-1:0]  i_data [fifo_length];
    logic                      o_valid;
    logic                      i_ready;
    logic [bits_per_cycle-1:0] o_slice [fifo_length];
    logic [idx_w-1:0]          o_slice_idx;
    logic                      o_last;
    logic                      o_done;

    modport slave (
        input  i_valid, i_data, i_ready,
        output o_ready, o_valid, o_slice, o_slice_idx, o_last, o_done
    );

    modport master (
        output i_valid, i_data, i_ready,
        input  o_ready, o_valid, o_slice, o_slice_idx, o_last, o_done
    );
endinterface

// File: rtl/ibuf_bitserial.sv
// Captures a fifo_length x datatype_size vector in one handshake and replays
// it as bit-plane slices (LSB slice first) to the crossbar wordline drivers.
//   clk, rstn : rising-edge clock, asynchronous active-low reset
//   bus       : ibuf_bitserial_if slave (vector in, slices out)
// o_ready is combinational from i_ready so a new vector can be accepted on the
// same edge as the last slice handshake (back-to-back, no idle gap).
module ibuf_bitserial #(
    parameter int unsigned datatype_size  = 8,
    parameter int unsigned fifo_length    = 5,
    parameter int unsigned bits_per_cycle = 1
) (
    input  logic              clk,
    input  logic              rstn,
    ibuf_bitserial_if.slave   bus
);
    localparam int unsigned num_slices = datatype_size / bits_per_cycle;
    localparam int unsigned idx_w      = (num_slices > 1) ? $clog2(num_slices) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                    state_q, state_d;
    logic [datatype_size-1:0]  shadow_q [fifo_length];
    logic [idx_w-1:0]          idx_q, idx_d;
    logic                      done_q, done_d;
    logic                      load;
    logic                      last;
    logic                      ready_c;
    logic [bits_per_cycle-1:0] plane [fifo_length][num_slices];

    assign last = (idx_q == idx_w'(num_slices - 1));

    // State, index and done-pulse registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // Shadow register is written only on an accepted input handshake
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < int'(fifo_length); k++) shadow_q[k] <= '0;
        end else if (load) begin
            for (int k = 0; k < int'(fifo_length); k++) shadow_q[k] <= bus.i_data[k];
        end
    end

    // Next-state, index and handshake decode
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        load    = 1'b0;
        ready_c = 1'b0;
        case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.i_valid) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.i_ready) begin
                    if (last) begin
                        done_d  = 1'b1;
                        ready_c = 1'b1;
                        idx_d   = '0;
                        if (bus.i_valid) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + idx_w'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Re-view the shadow register as per-element bit planes
    for (genvar k = 0; k < int'(fifo_length); k++) begin : g_elem
        for (genvar s = 0; s < int'(num_slices); s++) begin : g_plane
            assign plane[k][s] = shadow_q[k][s*bits_per_cycle +: bits_per_cycle];
        end
        assign bus.o_slice[k] = plane[k][idx_q];
    end

    assign bus.o_ready     = ready_c;
    assign bus.o_valid     = (state_q == SEND);
    assign bus.o_slice_idx = idx_q;
    assign bus.o_last      = (state_q == SEND) && last;
    assign bus.o_done      = done_q;
endmodule

// File: tb/tb_ibuf_bitserial.sv
module tb_ibuf_bitserial;
    logic clk = 1'b0;
    logic rstn;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    ibuf_bitserial_if #(.datatype_size(8), .fifo_length(5), .bits_per_cycle(1)) bus ();
    ibuf_bitserial_if #(.datatype_size(8), .fifo_length(5), .bits_per_cycle(4)) bus4 ();

    ibuf_bitserial #(.datatype_size(8), .fifo_length(5), .bits_per_cycle(1)) dut (
        .clk(clk), .rstn(rstn), .bus(bus)
    );
    ibuf_bitserial #(.datatype_size(8), .fifo_length(5), .bits_per_cycle(4)) dut4 (
        .clk(clk), .rstn(rstn), .bus(bus4)
    );

    logic [7:0] vec_a [5];
    logic [7:0] vec_b [5];
    logic [7:0] vec_c [5];
    logic [3:0] c_lo  [5];
    logic [3:0] c_hi  [5];

    task automatic load(input logic [7:0] v [5]);
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_ready = 1'b1;
        for (int k = 0; k < 5; k++) bus.i_data[k] = v[k];
        @(negedge clk);
        bus.i_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.i_valid = 0; bus.i_ready = 0; bus4.i_valid = 0; bus4.i_ready = 0;
        for (int k = 0; k < 5; k++) begin bus.i_data[k] = '0; bus4.i_data[k] = '0; end
        #1;
        tests++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", bus.o_valid); end
        tests++; if (bus.o_done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", bus.o_done); end
        tests++; if (bus.o_slice_idx !== 3'd0) begin fails++; $display("FAIL reset_idx got=%0d exp=0", bus.o_slice_idx); end
        for (int k = 0; k < 5; k++) begin
            tests++; if (bus.o_slice[k] !== 1'b0) begin fails++; $display("FAIL reset_slice[%0d] got=%b exp=0", k, bus.o_slice[k]); end
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1;
        tests++; if (bus.o_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", bus.o_ready); end
        tests++; if (bus4.o_ready !== 1'b1) begin fails++; $display("FAIL reset_ready4 got=%b exp=1", bus4.o_ready); end
    endtask

    task automatic test_basic();
        logic [4:0] s0_exp;
        logic [4:0] s7_exp;
        s0_exp = 5'b10101;
        s7_exp = 5'b00110;
        @(negedge clk);
        bus.i_valid = 1'b1; bus.i_ready = 1'b1;
        for (int k = 0; k < 5; k++) bus.i_data[k] = vec_a[k];
        #1;
        tests++; if (bus.o_ready !== 1'b1) begin fails++; $display("FAIL basic_accept_ready got=%b exp=1", bus.o_ready); end
        @(negedge clk);
        bus.i_valid = 1'b0;
        for (int s = 0; s < 8; s++) begin
            #1;
            tests++; if (bus.o_valid !== 1'b1) begin fails++; $display("FAIL basic_valid s=%0d got=%b exp=1", s, bus.o_valid); end
            tests++; if (bus.o_slice_idx !== 3'(s)) begin fails++; $display("FAIL basic_idx got=%0d exp=%0d", bus.o_slice_idx, s); end
            tests++; if (bus.o_last !== (s == 7)) begin fails++; $display("FAIL basic_last s=%0d got=%b", s, bus.o_last); end
            tests++; if (bus.o_done !== 1'b0) begin fails++; $display("FAIL basic_done_early s=%0d got=%b exp=0", s, bus.o_done); end
            tests++; if (bus.o_ready !== (s == 7)) begin fails++; $display("FAIL basic_ready s=%0d got=%b", s, bus.o_ready); end
            for (int k = 0; k < 5; k++) begin
                tests++; if (bus.o_slice[k] !== 1'(vec_a[k] >> s)) begin fails++; $display("FAIL basic_slice s=%0d k=%0d got=%b exp=%b", s, k, bus.o_slice[k], 1'(vec_a[k] >> s)); end
            end
            if (s == 0 || s == 7) begin
                for (int k = 0; k < 5; k++) begin
                    tests++;
                    if (bus.o_slice[k] !== ((s == 0) ? s0_exp[k] : s7_exp[k])) begin
                        fails++; $display("FAIL basic_hand_slice s=%0d k=%0d got=%b", s, k, bus.o_slice[k]);
                    end
                end
            end
            @(negedge clk);
        end
        tests++; if (bus.o_done !== 1'b1) begin fails++; $display("FAIL basic_done got=%b exp=1", bus.o_done); end
        tests++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL basic_idle_valid got=%b exp=0", bus.o_valid); end
        tests++; if (bus.o_ready !== 1'b1) begin fails++; $display("FAIL basic_idle_ready got=%b exp=1", bus.o_ready); end
        @(negedge clk);
        tests++; if (bus.o_done !== 1'b0) begin fails++; $display("FAIL basic_done_pulse got=%b exp=0", bus.o_done); end
    endtask

    task automatic test_backpressure();
        logic pat [4];
        int   s;
        int   c;
        logic r;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        load(vec_a);
        s = 0;
        c = 0;
        while (s < 8 && c < 64) begin
            r = pat[c % 4];
            bus.i_ready = r;
            #1;
            tests++; if (bus.o_valid !== 1'b1) begin fails++; $display("FAIL bp_valid c=%0d got=%b exp=1", c, bus.o_valid); end
            tests++; if (bus.o_slice_idx !== 3'(s)) begin fails++; $display("FAIL bp_idx c=%0d got=%0d exp=%0d", c, bus.o_slice_idx, s); end
            tests++; if (bus.o_ready !== (s == 7 && r)) begin fails++; $display("FAIL bp_ready c=%0d got=%b", c, bus.o_ready); end
            for (int k = 0; k < 5; k++) begin
                tests++; if (bus.o_slice[k] !== 1'(vec_a[k] >> s)) begin fails++; $display("FAIL bp_slice s=%0d k=%0d got=%b", s, k, bus.o_slice[k]); end
            end
            @(negedge clk);
            if (r) s++;
            c++;
        end
        tests++; if (s != 8) begin fails++; $display("FAIL bp_timeout slices=%0d exp=8", s); end
        tests++; if (bus.o_done !== 1'b1) begin fails++; $display("FAIL bp_done got=%b exp=1", bus.o_done); end
        bus.i_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        load(vec_a);
        for (int s = 0; s < 7; s++) @(negedge clk);
        tests++; if (bus.o_slice_idx !== 3'd7) begin fails++; $display("FAIL b2b_pre_idx got=%0d exp=7", bus.o_slice_idx); end
        bus.i_valid = 1'b1;
        for (int k = 0; k < 5; k++) bus.i_data[k] = vec_b[k];
        #1;
        tests++; if (bus.o_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready got=%b exp=1", bus.o_ready); end
        @(negedge clk);
        bus.i_valid = 1'b0;
        tests++; if (bus.o_done !== 1'b1) begin fails++; $display("FAIL b2b_done got=%b exp=1", bus.o_done); end
        tests++; if (bus.o_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid got=%b exp=1", bus.o_valid); end
        tests++; if (bus.o_slice_idx !== 3'd0) begin fails++; $display("FAIL b2b_idx got=%0d exp=0", bus.o_slice_idx); end
        for (int k = 0; k < 5; k++) begin
            tests++; if (bus.o_slice[k] !== 1'b0) begin fails++; $display("FAIL b2b_s0 k=%0d got=%b exp=0", k, bus.o_slice[k]); end
        end
        @(negedge clk);
        tests++; if (bus.o_done !== 1'b0) begin fails++; $display("FAIL b2b_done_pulse got=%b exp=0", bus.o_done); end
        for (int s = 1; s < 8; s++) begin
            tests++; if (bus.o_slice_idx !== 3'(s)) begin fails++; $display("FAIL b2b_idx got=%0d exp=%0d", bus.o_slice_idx, s); end
            for (int k = 0; k < 5; k++) begin
                tests++; if (bus.o_slice[k] !== 1'(s % 2)) begin fails++; $display("FAIL b2b_slice s=%0d k=%0d got=%b", s, k, bus.o_slice[k]); end
            end
            @(negedge clk);
        end
        tests++; if (bus.o_done !== 1'b1) begin fails++; $display("FAIL b2b_done2 got=%b exp=1", bus.o_done); end
        @(negedge clk);
    endtask

    task automatic test_bpc4();
        @(negedge clk);
        bus4.i_valid = 1'b1; bus4.i_ready = 1'b1;
        for (int k = 0; k < 5; k++) bus4.i_data[k] = vec_c[k];
        @(negedge clk);
        bus4.i_valid = 1'b0;
        tests++; if (bus4.o_slice_idx !== 1'b0) begin fails++; $display("FAIL bpc4_idx0 got=%0d exp=0", bus4.o_slice_idx); end
        tests++; if (bus4.o_last !== 1'b0) begin fails++; $display("FAIL bpc4_last0 got=%b exp=0", bus4.o_last); end
        for (int k = 0; k < 5; k++) begin
            tests++; if (bus4.o_slice[k] !== c_lo[k]) begin fails++; $display("FAIL bpc4_lo k=%0d got=%h exp=%h", k, bus4.o_slice[k], c_lo[k]); end
        end
        @(negedge clk);
        tests++; if (bus4.o_slice_idx !== 1'b1) begin fails++; $display("FAIL bpc4_idx1 got=%0d exp=1", bus4.o_slice_idx); end
        tests++; if (bus4.o_last !== 1'b1) begin fails++; $display("FAIL bpc4_last1 got=%b exp=1", bus4.o_last); end
        for (int k = 0; k < 5; k++) begin
            tests++; if (bus4.o_slice[k] !== c_hi[k]) begin fails++; $display("FAIL bpc4_hi k=%0d got=%h exp=%h", k, bus4.o_slice[k], c_hi[k]); end
        end
        @(negedge clk);
        tests++; if (bus4.o_done !== 1'b1) begin fails++; $display("FAIL bpc4_done got=%b exp=1", bus4.o_done); end
        tests++; if (bus4.o_valid !== 1'b0) begin fails++; $display("FAIL bpc4_idle got=%b exp=0", bus4.o_valid); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        load(vec_a);
        repeat (3) @(negedge clk);
        tests++; if (bus.o_slice_idx !== 3'd3) begin fails++; $display("FAIL rmid_pre_idx got=%0d exp=3", bus.o_slice_idx); end
        bus.i_ready = 1'b0;
        #2 rstn = 1'b0;
        #1;
        tests++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL rmid_async_valid got=%b exp=0", bus.o_valid); end
        tests++; if (bus.o_slice_idx !== 3'd0) begin fails++; $display("FAIL rmid_idx got=%0d exp=0", bus.o_slice_idx); end
        for (int k = 0; k < 5; k++) begin
            tests++; if (bus.o_slice[k] !== 1'b0) begin fails++; $display("FAIL rmid_slice k=%0d got=%b exp=0", k, bus.o_slice[k]); end
        end
        repeat (2) @(negedge clk);
        tests++; if (bus.o_done !== 1'b0) begin fails++; $display("FAIL rmid_done_in_reset got=%b exp=0", bus.o_done); end
        rstn = 1'b1;
        #1;
        tests++; if (bus.o_ready !== 1'b1) begin fails++; $display("FAIL rmid_ready got=%b exp=1", bus.o_ready); end
        @(negedge clk);
        tests++; if (bus.o_done !== 1'b0) begin fails++; $display("FAIL rmid_no_done got=%b exp=0", bus.o_done); end
        load(vec_b);
        tests++; if (bus.o_valid !== 1'b1) begin fails++; $display("FAIL rmid_new_valid got=%b exp=1", bus.o_valid); end
        tests++; if (bus.o_slice_idx !== 3'd0) begin fails++; $display("FAIL rmid_new_idx got=%0d exp=0", bus.o_slice_idx); end
        for (int k = 0; k < 5; k++) begin
            tests++; if (bus.o_slice[k] !== 1'(vec_b[k])) begin fails++; $display("FAIL rmid_new_slice k=%0d got=%b", k, bus.o_slice[k]); end
        end
        bus.i_ready = 1'b1;
        repeat (9) @(negedge clk);
    endtask

    task automatic test_data_change();
        load(vec_c);
        for (int s = 0; s < 8; s++) begin
            for (int k = 0; k < 5; k++) bus.i_data[k] = 8'($urandom);
            #1;
            for (int k = 0; k < 5; k++) begin
                tests++; if (bus.o_slice[k] !== 1'(vec_c[k] >> s)) begin fails++; $display("FAIL dchg_slice s=%0d k=%0d got=%b", s, k, bus.o_slice[k]); end
            end
            @(negedge clk);
        end
        tests++; if (bus.o_done !== 1'b1) begin fails++; $display("FAIL dchg_done got=%b exp=1", bus.o_done); end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_a[0] = 8'h01; vec_a[1] = 8'h80; vec_a[2] = 8'hFF; vec_a[3] = 8'h00; vec_a[4] = 8'h55;
        for (int k = 0; k < 5; k++) vec_b[k] = 8'hAA;
        vec_c[0] = 8'h3C; vec_c[1] = 8'h12; vec_c[2] = 8'hF0; vec_c[3] = 8'h0F; vec_c[4] = 8'hA5;
        c_lo[0] = 4'hC; c_lo[1] = 4'h2; c_lo[2] = 4'h0; c_lo[3] = 4'hF; c_lo[4] = 4'h5;
        c_hi[0] = 4'h3; c_hi[1] = 4'h1; c_hi[2] = 4'hF; c_hi[3] = 4'h0; c_hi[4] = 4'hA;

        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_bpc4();
        test_reset_mid();
        test_data_change();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ibuf_bitserial.md
Name: ibuf_bitserial

Overview:
- Downstream of the input shift buffer: captures the fifo_length x datatype_size input vector in one handshake.
- Replays it to the CIM crossbar wordline drivers as bit-plane slices, LSB slice first, bits_per_cycle bits of every element per slice.
- Valid/ready on both sides. The crossbar/ADC side can stall each slice.

Parameters:
- datatype_size, 8, width of each buffered element in bits.
- fifo_length, 5, number of elements (crossbar rows) in the vector.
- bits_per_cycle, 1, bits per element per slice; must divide datatype_size. NUM_SLICES = datatype_size/bits_per_cycle (localparam).

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous active-low reset.
- i_valid  input  1  upstream vector valid.
- o_ready  output  1  block can accept a vector this cycle.
- i_data  input  datatype_size x [fifo_length] unpacked  vector from the input buffer; element 0 is the newest.
- o_valid  output  1  o_slice holds a valid slice.
- i_ready  input  1  crossbar accepts the current slice.
- o_slice  output  bits_per_cycle x [fifo_length] unpacked  current slice; o_slice[k] = i_data_latched[k][s*bits_per_cycle +: bits_per_cycle].
- o_slice_idx  output  clog2(NUM_SLICES), min 1  index s of the current slice, used as the shift-add weight.
- o_last  output  1  current slice is s == NUM_SLICES-1.
- o_done  output  1  one-cycle pulse after the last slice is accepted.

Behaviour:
- Reset (rstn low, async): state=IDLE, shadow register=0, slice index=0, o_valid=0, o_done=0. o_ready is 1 once reset is released. o_slice shows the zeroed shadow register.
- States:
  - IDLE: o_ready=1, o_valid=0. When i_valid&&o_ready: latch all of i_data into the shadow register, set index=0, go to SEND. There is no bubble, so o_valid=1 on the next cycle.
  - SEND: o_valid=1. o_slice and o_slice_idx come from registers only; no combinational path from i_data.
  - SEND with i_ready=1 and index<NUM_SLICES-1: index++.
  - SEND with i_ready=1 and index==NUM_SLICES-1: set o_done=1 on the next cycle. If i_valid is also 1, latch the new vector, set index=0 and stay in SEND (back-to-back). Otherwise go to IDLE.
  - SEND with i_ready=0: hold index, o_slice and o_valid stable. This is AXI-style: o_valid never drops without a handshake.
- o_ready = (state==IDLE) || (state==SEND && o_last && i_ready). This is a combinational path from i_ready and is documented.
- Throughput and latency:
  - Minimum NUM_SLICES cycles per vector.
  - First slice appears 1 cycle after the input handshake.
  - o_done appears 1 cycle after the last slice handshake.
- Data rules:
  - Elements are unsigned raw bits, sliced without sign extension. Weighting and sign correction happen downstream using o_slice_idx.
  - The shadow register is written only on an input handshake. i_data changing mid-vector has no effect.
- NUM_SLICES==1 (bits_per_cycle==datatype_size): o_last is always 1 in SEND. Every accepted slice ends the vector.
- i_valid while busy and not on the last handshake: ignored. o_ready=0, and upstream must hold.
- Reset asserted mid-vector: the vector is abandoned immediately and no o_done is generated. Downstream must also reset.

Test Plan:
- Defaults, vector {0x01,0x80,0xFF,0x00,0x55}, i_ready=1:
  - 8 consecutive slices s=0..7.
  - s=0 gives o_slice={1,0,1,0,1}; s=7 gives {0,1,1,0,0}.
  - o_last only at s=7; o_done pulse exactly 1 cycle later; o_ready returns high.
- Backpressure: same vector, i_ready toggling 1,0,0,1,... -> each slice held stable while i_ready=0; index advances only on a handshake; all 8 slices delivered in order.
- Back-to-back: second vector {0xAA x5} with i_valid held high during the last slice handshake -> next cycle shows s=0 of the new vector (all 0); o_done=1 in the same cycle; no IDLE gap.
- bits_per_cycle=4, vector {0x3C,...} -> 2 slices; o_slice[0]=0xC then 0x3; NUM_SLICES=2.
- Reset mid-vector: assert rstn low at s=3 -> outputs clear asynchronously (o_valid=0 without waiting for a clock); no o_done; after release, o_ready=1 and a new vector starts at s=0.
- i_data changes every cycle during SEND -> the output slices still match the vector latched at the handshake.
